// File: rtl/sw_debouncer.sv
`default_nettype none
// ============================================================================
// sw_debouncer : 2-flop synchronizer + per-bit debounce FSM with rise/fall pulses
// Rev 1.0
// ============================================================================
module sw_debouncer #(
    parameter int NB_SW       = 4,
    parameter int NB_DBNC     = 16,
    parameter int DBNC_CYCLES = 50000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_sw_rise,
    output logic [NB_SW-1:0] o_sw_fall
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [NB_DBNC-1:0] C_CNT_LAST  = NB_DBNC'(DBNC_CYCLES - 1);
    localparam logic [NB_DBNC-1:0] C_CNT_FIRST = NB_DBNC'(1);

    logic [NB_SW-1:0] r_sw_s1;
    logic [NB_SW-1:0] r_sw_s2;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= i_sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    for (genvar i = 0; i < NB_SW; i++) begin : g_bit
        state_t             r_state;
        logic [NB_DBNC-1:0] r_cnt;
        logic               r_level;
        logic               r_rise;
        logic               r_fall;

        // The detection cycle already counts as the first stable sample, so
        // acceptance lands DBNC_CYCLES samples after the new level reaches sw_s2.
        always_ff @(posedge clock or negedge i_reset) begin
            if (!i_reset) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                case (r_state)
                    ST_STABLE: begin
                        r_cnt <= '0;
                        if (r_sw_s2[i] != r_level) begin
                            r_state <= ST_PENDING;
                            r_cnt   <= C_CNT_FIRST;
                        end
                    end
                    ST_PENDING: begin
                        if (r_sw_s2[i] == r_level) begin
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == C_CNT_LAST) begin
                            r_level <= r_sw_s2[i];
                            r_rise  <= r_sw_s2[i];
                            r_fall  <= ~r_sw_s2[i];
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign o_sw[i]      = r_level;
        assign o_sw_rise[i] = r_rise;
        assign o_sw_fall[i] = r_fall;
    end

endmodule
`default_nettype wire

// File: tb/tb_sw_debouncer.sv
`default_nettype none
// ============================================================================
// tb_sw_debouncer : directed self-checking bench for sw_debouncer (DBNC_CYCLES=8)
// Rev 1.0
// ============================================================================
module tb_sw_debouncer;

    localparam int C_NB_SW = 4;

    logic               clock;
    logic               i_reset;
    logic [C_NB_SW-1:0] i_sw;
    logic [C_NB_SW-1:0] o_sw;
    logic [C_NB_SW-1:0] o_sw_rise;
    logic [C_NB_SW-1:0] o_sw_fall;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [C_NB_SW-1:0] pulse_seen;

    sw_debouncer #(
        .NB_SW      (C_NB_SW),
        .NB_DBNC    (4),
        .DBNC_CYCLES(8)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_sw     (i_sw),
        .o_sw     (o_sw),
        .o_sw_rise(o_sw_rise),
        .o_sw_fall(o_sw_fall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling 1 ns after each and accumulating any pulse.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            pulse_seen = pulse_seen | o_sw_rise | o_sw_fall;
        end
    endtask

    // Apply a level and check the full 10-edge acceptance window.
    task automatic accept(input string tag, input logic [3:0] old_v, input logic [3:0] new_v);
        i_sw = new_v;
        pulse_seen = '0;
        tick(9);
        chk({tag, "_pre"}, o_sw, old_v);
        chk({tag, "_prepulse"}, pulse_seen, 4'h0);
        tick(1);
        chk({tag, "_sw"}, o_sw, new_v);
        chk({tag, "_rise"}, o_sw_rise, new_v & ~old_v);
        chk({tag, "_fall"}, o_sw_fall, old_v & ~new_v);
        tick(1);
        chk({tag, "_rise_end"}, o_sw_rise, 4'h0);
        chk({tag, "_fall_end"}, o_sw_fall, 4'h0);
        chk({tag, "_hold"}, o_sw, new_v);
    endtask

    initial begin
        pulse_seen = '0;
        i_reset = 1'b0;
        i_sw    = 4'hF;

        // 1: reset state, then power-up acceptance of 4'hF
        tick(3);
        chk("rst_sw", o_sw, 4'h0);
        chk("rst_rise", o_sw_rise, 4'h0);
        chk("rst_fall", o_sw_fall, 4'h0);
        i_reset = 1'b1;
        accept("t1", 4'h0, 4'hF);

        // 2: 5-cycle glitch on bit0 is rejected
        accept("t2_setup", 4'hF, 4'hE);
        i_sw = 4'hF;
        pulse_seen = '0;
        tick(5);
        i_sw = 4'hE;
        tick(15);
        chk("t2_glitch_sw", o_sw, 4'hE);
        chk("t2_glitch_pulse", pulse_seen, 4'h0);

        // 3: bouncing burst on bit2, then a steady high
        accept("t3_setup", 4'hE, 4'hA);
        pulse_seen = '0;
        i_sw = 4'hE; tick(1);
        i_sw = 4'hA; tick(1);
        i_sw = 4'hE; tick(2);
        i_sw = 4'hA; tick(1);
        chk("t3_burst_pulse", pulse_seen, 4'h0);
        accept("t3", 4'hA, 4'hE);

        // 4: falling edge on bit3
        accept("t4_setup", 4'hE, 4'hF);
        accept("t4", 4'hF, 4'h7);

        // 5: reset in the middle of a pending count
        accept("t5_setup", 4'h7, 4'h0);
        i_sw = 4'h2;
        tick(5);
        i_reset = 1'b0;
        #1;
        chk("t5_rst_sw", o_sw, 4'h0);
        tick(3);
        chk("t5_rst_hold", o_sw, 4'h0);
        chk("t5_rst_rise", o_sw_rise, 4'h0);
        i_reset = 1'b1;
        accept("t5", 4'h0, 4'h2);

        // 6: simultaneous change on two bits
        accept("t6_setup", 4'h2, 4'h0);
        accept("t6", 4'h0, 4'h5);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
